prio_arbiter: RTL and testbench

Registered, parametrised N-way priority arbiter with a valid/ready output handshake and optional grant locking. It replaces the combinational 4:2 priority encoder wherever a shared resource must be granted to one of N requesters and the decision must stay stable until consumed. Example resources are a bus port or a shared FIFO write side. The winner index is presented both binary-encoded and one-hot. The priority scheme is fixed (highest index wins) or rotating round-robin, selected at compile time.

---
 rtl/prio_arbiter.sv | 148 ++++++++++++++
 tb/tb_prio_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// Registered N-way priority arbiter with valid/ready grant handshake and grant locking.
// Define PRIO_ARBITER_ROUND_ROBIN_EN for round-robin selection; otherwise the highest index wins.
module prio_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         lock,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] gnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] gnt_q, gnt_d;

  logic         any_req;
  logic         accept;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;

  assign any_req = |req;
  // out_valid is high exactly in GRANT, so accept only needs the state.
  assign accept  = (state_q == ST_GRANT) & out_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == W'(gi));
  end

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0] search_base;
  logic         found;

  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    return (v == W'(N - 1)) ? '0 : v + W'(1);
  endfunction

  // A re-arbitration in GRANT must already see the pointer moved past the
  // accepted owner, which is not registered until this same edge.
  always_comb begin
    int pos;
    search_base = (state_q == ST_GRANT) ? wrap_inc(idx_q) : rr_ptr_q;
    win_idx     = search_base;
    found       = 1'b0;
    pos         = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(search_base) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        win_idx = W'(pos);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = accept ? wrap_inc(idx_q) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) win_idx = W'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          valid_d = 1'b1;
          idx_d   = win_idx;
          gnt_d   = win_onehot;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          if (lock) begin
            state_d = ST_HOLD;
            valid_d = 1'b0;
          end else if (any_req) begin
            idx_d = win_idx;
            gnt_d = win_onehot;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            gnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (!req[idx_q]) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          idx_d   = '0;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign gnt       = gnt_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=8 and N=5 instances); expectations follow
// whichever selection mode PRIO_ARBITER_ROUND_ROBIN_EN picks.
module tb_prio_arbiter;

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       lock, ready;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] gnt;

  logic [4:0] req5;
  logic       lock5, ready5;
  logic       valid5;
  logic [2:0] idx5;
  logic [4:0] gnt5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_arbiter #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .out_ready(ready),
    .out_valid(valid), .out_idx(idx), .gnt(gnt)
  );

  prio_arbiter #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .lock(lock5), .out_ready(ready5),
    .out_valid(valid5), .out_idx(idx5), .gnt(gnt5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic v, input logic [2:0] i, input logic [7:0] g);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, "_idx"}, {29'd0, idx}, {29'd0, i});
    chk({tag, "_gnt"}, {24'd0, gnt}, {24'd0, g});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] e;
    rst_n = 1'b0; req = '0; lock = 1'b0; ready = 1'b0;
    req5 = '0; lock5 = 1'b0; ready5 = 1'b0;
    step(); step();
    chk8("reset", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;

    // Empty requests for 10 cycles
    for (int k = 0; k < 10; k++) begin
      step();
      chk("empty_valid", {31'd0, valid}, 32'd0);
      chk("empty_gnt", {24'd0, gnt}, 32'd0);
    end

    // Grant from IDLE, then frozen while not accepted
    req = 8'hA4;
    step();
    e = RR ? 3'd2 : 3'd7;
    chk8("first_grant", 1'b1, e, 8'h01 << e);
    req = 8'h01;
    for (int k = 0; k < 5; k++) begin
      step();
      chk8("frozen", 1'b1, e, 8'h01 << e);
    end

    // Accept with no requests pending -> IDLE
    ready = 1'b1; req = 8'h00;
    step();
    chk8("accept_empty", 1'b0, 3'd0, 8'h00);
    ready = 1'b0;

    // Lock and hold
    req = 8'h08;
    step();
    chk8("lock_grant", 1'b1, 3'd3, 8'h08);
    ready = 1'b1; lock = 1'b1;
    step();
    chk8("hold_enter", 1'b0, 3'd3, 8'h08);
    ready = 1'b0; lock = 1'b0; req = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      step();
      chk8("hold_keep", 1'b0, 3'd3, 8'h08);
    end
    req = 8'h07;
    step();
    chk8("hold_release", 1'b0, 3'd0, 8'h00);
    step();
    e = RR ? 3'd0 : 3'd2;
    chk8("after_hold", 1'b1, e, 8'h01 << e);
    ready = 1'b1; req = 8'h00;
    step();
    chk8("clear", 1'b0, 3'd0, 8'h00);
    ready = 1'b0;

    // Asynchronous reset in the middle of a grant
    req = 8'h40;
    step();
    chk8("pre_reset", 1'b1, 3'd6, 8'h40);
    #3;
    rst_n = 1'b0;
    #1;
    chk8("async_reset", 1'b0, 3'd0, 8'h00);
    req = 8'hFF;
    step();
    rst_n = 1'b1;
    step();
    e = RR ? 3'd0 : 3'd7;
    chk8("post_reset", 1'b1, e, 8'h01 << e);

    // Back-to-back grants with all requests held
    ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      e = RR ? 3'(k % 8) : 3'd7;
      chk8("b2b", 1'b1, e, 8'h01 << e);
    end
    ready = 1'b0; req = 8'h00;

    // Non-power-of-two instance
    req5 = 5'h11; ready5 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      e = (RR && (k % 2 == 0)) ? 3'd0 : 3'd4;
      chk("n5_valid", {31'd0, valid5}, 32'd1);
      chk("n5_idx", {29'd0, idx5}, {29'd0, e});
      chk("n5_gnt", {27'd0, gnt5}, {27'd0, 5'h01 << e});
      chk("n5_idx_range", {31'd0, (idx5 < 3'd5)}, 32'd1);
    end
    ready5 = 1'b1; req5 = '0;
    step();
    chk("n5_idle_valid", {31'd0, valid5}, 32'd0);
    chk("n5_idle_gnt", {27'd0, gnt5}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
